mem_rdret_2ru: RTL and testbench
================================

MEM_RDRET_2RU -- requirements
Module: mem_rdret_2ru

Interface
REQ-001 Parameter AW, default 10, memory address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter TW, default 4, request tag width.
REQ-004 Parameter LATENCY, default 2, read latency of the downstream 2-port memory; legal range 0..29.
REQ-005 Parameter FIFO_DEPTH, default 4, power of two, per-port response FIFO depth, SHALL be >= LATENCY+1.
REQ-006 clk  input  1  single clock; all logic on posedge clk.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 Ports are listed once with suffix _p, and each SHALL exist for p=0 and p=1.
REQ-009 rreq_vld_p  input  1  read request valid.
REQ-010 rreq_rdy_p  output  1  read request accepted when vld&rdy.
REQ-011 rreq_addr_p  input  AW  read address.
REQ-012 rreq_tag_p  input  TW  requester tag, returned with data.
REQ-013 read_p  output  1  memory read strobe.
REQ-014 addr_p  output  AW  memory address.
REQ-015 dout_p  input  DW  memory read data, valid LATENCY cycles after read_p.
REQ-016 rsp_vld_p  output  1  response valid.
REQ-017 rsp_rdy_p  input  1  response consumed when vld&rdy.
REQ-018 rsp_data_p  output  DW  response data.
REQ-019 rsp_tag_p  output  TW  response tag.

Function
REQ-020 Ports 0 and 1 SHALL be fully independent, with no shared state.
REQ-021 Accept = rreq_vld_p & rreq_rdy_p; read_p SHALL equal accept combinationally, and addr_p SHALL equal rreq_addr_p.
REQ-022 rreq_rdy_p SHALL be ~rst & (fifo_count_p + inflight_p < FIFO_DEPTH), so space is credit-reserved at issue.
REQ-023 A LATENCY-stage valid+tag shift pipe SHALL track each accept, and inflight_p SHALL count its valid stages.
REQ-024 When a tracked stage reaches LATENCY, dout_p and its tag SHALL be pushed into the FIFO that same cycle; for LATENCY=0, dout_p SHALL be captured in the accept cycle.
REQ-025 Accept to earliest rsp_vld_p SHALL take exactly LATENCY+1 cycles; there is no bypass.
REQ-026 Responses SHALL return in accept order per port.
REQ-027 rsp_vld_p = FIFO non-empty; rsp_data_p/rsp_tag_p = FIFO head, held stable while vld&~rdy.
REQ-028 Simultaneous push and pop SHALL leave the count unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 Overflow SHALL be impossible by REQ-022; a push while full SHALL raise `ERROR.
REQ-030 rsp_vld_p SHALL NOT depend combinationally on rsp_rdy_p.

Reset
REQ-031 While rst=1: FIFOs emptied, pipe valids cleared, inflight_p=0, rsp_vld_p=0, rreq_rdy_p=0, read_p=0.
REQ-032 Reads in flight at reset SHALL be discarded, and their later dout_p returns SHALL be ignored.
REQ-033 In the first cycle after rst deasserts, rreq_rdy_p SHALL be 1.

Configuration
REQ-034 Macro MEM_RDRET_2RU_ERR_EN: when defined, inputs read_serr_p/read_derr_p (1 bit) SHALL be captured with dout_p and presented on outputs rsp_serr_p/rsp_derr_p, aligned with rsp_data_p.
REQ-035 Without MEM_RDRET_2RU_ERR_EN, those ports and their FIFO bits SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
REQ-036 LATENCY=2: accept addr=0x10 tag=3 at cycle 5, rsp_rdy=1 -> rsp_vld=1 at cycle 8 with mem[0x10], tag 3.
REQ-037 FIFO_DEPTH=4, rsp_rdy=0, continuous vld -> exactly 4 accepts, then rreq_rdy=0; raising rsp_rdy for 1 cycle -> rreq_rdy=1 the next cycle.
REQ-038 Tags 0,1,2,3 back-to-back with random rsp_rdy stalls -> responses in order 0,1,2,3, data stable during stalls.
REQ-039 Assert rst for 1 cycle with 2 reads in flight -> rsp_vld stays 0, no response for those tags, rreq_rdy=1 after rst.
REQ-040 Port 0 stalled full, port 1 streaming -> port 1 throughput 1 response/cycle, unaffected.
REQ-041 LATENCY=0, FIFO_DEPTH=1: accept -> rsp_vld next cycle, and rreq_rdy=0 until popped.

Source files
------------

// File: rtl/mem_rdret_2ru.sv
// mem_rdret_2ru -- dual independent read-return adapters for a 2-port memory.
//
// Each port p (0 and 1) accepts tagged read requests, issues them straight to
// the downstream memory port, tracks them through a LATENCY-deep valid+tag pipe
// and parks the returning data in a per-port response FIFO. FIFO space is
// reserved when a read is issued, so returning data always has a slot.
//
// Ports (per p in {0,1}):
//   rreq_vld_p/rreq_rdy_p/rreq_addr_p/rreq_tag_p  request handshake
//   read_p/addr_p                                  memory read strobe/address
//   dout_p                                         memory data, LATENCY cycles after read_p
//   rsp_vld_p/rsp_rdy_p/rsp_data_p/rsp_tag_p       response handshake
// Optional (macro MEM_RDRET_2RU_ERR_EN):
//   read_serr_p/read_derr_p in, rsp_serr_p/rsp_derr_p out, aligned with data.
// clk: single clock; rst: synchronous, active-high.

`ifndef ERROR
`define ERROR $error("mem_rdret_2ru: response FIFO push while full")
`endif

module mem_rdret_2ru_port #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int TW         = 4,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rreq_vld_i,
  output logic          rreq_rdy_o,
  input  logic [AW-1:0] rreq_addr_i,
  input  logic [TW-1:0] rreq_tag_i,
  output logic          read_o,
  output logic [AW-1:0] addr_o,
  input  logic [DW-1:0] dout_i,
`ifdef MEM_RDRET_2RU_ERR_EN
  input  logic          read_serr_i,
  input  logic          read_derr_i,
  output logic          rsp_serr_o,
  output logic          rsp_derr_o,
`endif
  output logic          rsp_vld_o,
  input  logic          rsp_rdy_i,
  output logic [DW-1:0] rsp_data_o,
  output logic [TW-1:0] rsp_tag_o
);

`ifdef MEM_RDRET_2RU_ERR_EN
  localparam int EBW = 2;
`else
  localparam int EBW = 0;
`endif
  localparam int EW = DW + TW + EBW;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(FIFO_DEPTH + LATENCY + 1) + 1;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic          accept, push, pop;
  logic [TW-1:0] push_tag;
  logic [SW-1:0] inflight, occ;
  logic [EW-1:0] push_ent, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Occupancy counts both stored responses and reads still in the memory
  // pipe, so an issued read always has a FIFO slot when its data returns.
  always_comb begin
    occ        = SW'(count_q) + inflight;
    rreq_rdy_o = ~rst_i & (occ < SW'(FIFO_DEPTH));
  end

  assign accept    = rreq_vld_i & rreq_rdy_o;
  assign read_o    = accept;
  assign addr_o    = rreq_addr_i;
  assign rsp_vld_o = ~rst_i & (count_q != '0);
  assign pop       = rsp_vld_o & rsp_rdy_i;

  generate
    if (LATENCY == 0) begin : g_nopipe
      // Data is valid in the accept cycle itself.
      assign push     = accept;
      assign push_tag = rreq_tag_i;
      assign inflight = '0;
    end else begin : g_pipe
      localparam int unsigned LU = LATENCY;
      logic [LATENCY-1:0] pv_q;
      logic [TW-1:0]      pt_q [LATENCY];

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          pv_q <= '0;
        end else begin
          pv_q[0] <= accept;
          for (int unsigned s = 1; s < LU; s++) pv_q[s] <= pv_q[s-1];
        end
      end

      always_ff @(posedge clk_i) begin
        pt_q[0] <= rreq_tag_i;
        for (int unsigned s = 1; s < LU; s++) pt_q[s] <= pt_q[s-1];
      end

      // Last stage is live in the cycle the memory presents its data.
      assign push     = pv_q[LATENCY-1];
      assign push_tag = pt_q[LATENCY-1];

      always_comb begin
        inflight = '0;
        for (int unsigned s = 0; s < LU; s++) inflight = inflight + SW'(pv_q[s]);
      end
    end
  endgenerate

`ifdef MEM_RDRET_2RU_ERR_EN
  assign push_ent   = {read_derr_i, read_serr_i, push_tag, dout_i};
  assign rsp_serr_o = head[DW+TW];
  assign rsp_derr_o = head[DW+TW+1];
`else
  assign push_ent   = {push_tag, dout_i};
`endif

  assign head       = mem_q[rd_ptr_q];
  assign rsp_data_o = head[DW-1:0];
  assign rsp_tag_o  = head[DW+TW-1:DW];

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) mem_q[wr_ptr_q] <= push_ent;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      assert (!(push && (count_q == CW'(FIFO_DEPTH)))) else `ERROR;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

module mem_rdret_2ru #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int TW         = 4,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rreq_vld_0,
  output logic          rreq_rdy_0,
  input  logic [AW-1:0] rreq_addr_0,
  input  logic [TW-1:0] rreq_tag_0,
  output logic          read_0,
  output logic [AW-1:0] addr_0,
  input  logic [DW-1:0] dout_0,
  output logic          rsp_vld_0,
  input  logic          rsp_rdy_0,
  output logic [DW-1:0] rsp_data_0,
  output logic [TW-1:0] rsp_tag_0,
  input  logic          rreq_vld_1,
  output logic          rreq_rdy_1,
  input  logic [AW-1:0] rreq_addr_1,
  input  logic [TW-1:0] rreq_tag_1,
  output logic          read_1,
  output logic [AW-1:0] addr_1,
  input  logic [DW-1:0] dout_1,
`ifdef MEM_RDRET_2RU_ERR_EN
  input  logic          read_serr_0,
  input  logic          read_derr_0,
  output logic          rsp_serr_0,
  output logic          rsp_derr_0,
  input  logic          read_serr_1,
  input  logic          read_derr_1,
  output logic          rsp_serr_1,
  output logic          rsp_derr_1,
`endif
  output logic          rsp_vld_1,
  input  logic          rsp_rdy_1,
  output logic [DW-1:0] rsp_data_1,
  output logic [TW-1:0] rsp_tag_1
);

  mem_rdret_2ru_port #(
    .AW(AW), .DW(DW), .TW(TW), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) u_port0 (
    .clk_i(clk), .rst_i(rst),
    .rreq_vld_i(rreq_vld_0), .rreq_rdy_o(rreq_rdy_0),
    .rreq_addr_i(rreq_addr_0), .rreq_tag_i(rreq_tag_0),
    .read_o(read_0), .addr_o(addr_0), .dout_i(dout_0),
`ifdef MEM_RDRET_2RU_ERR_EN
    .read_serr_i(read_serr_0), .read_derr_i(read_derr_0),
    .rsp_serr_o(rsp_serr_0), .rsp_derr_o(rsp_derr_0),
`endif
    .rsp_vld_o(rsp_vld_0), .rsp_rdy_i(rsp_rdy_0),
    .rsp_data_o(rsp_data_0), .rsp_tag_o(rsp_tag_0)
  );

  mem_rdret_2ru_port #(
    .AW(AW), .DW(DW), .TW(TW), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) u_port1 (
    .clk_i(clk), .rst_i(rst),
    .rreq_vld_i(rreq_vld_1), .rreq_rdy_o(rreq_rdy_1),
    .rreq_addr_i(rreq_addr_1), .rreq_tag_i(rreq_tag_1),
    .read_o(read_1), .addr_o(addr_1), .dout_i(dout_1),
`ifdef MEM_RDRET_2RU_ERR_EN
    .read_serr_i(read_serr_1), .read_derr_i(read_derr_1),
    .rsp_serr_o(rsp_serr_1), .rsp_derr_o(rsp_derr_1),
`endif
    .rsp_vld_o(rsp_vld_1), .rsp_rdy_i(rsp_rdy_1),
    .rsp_data_o(rsp_data_1), .rsp_tag_o(rsp_tag_1)
  );

endmodule

// File: tb/tb_mem_rdret_2ru.sv
// Bench for mem_rdret_2ru: instance 0 uses LATENCY=2/FIFO_DEPTH=4, instance 1
// uses LATENCY=0/FIFO_DEPTH=1. A reference model keeps, per port, the list of
// outstanding reads (accept cycle, expected data, tag) and derives ready,
// response valid and response contents from that list.
module tb_mem_rdret_2ru;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld   [2][2];
  logic        rdy   [2][2];
  logic [9:0]  raddr [2][2];
  logic [3:0]  rtag  [2][2];
  logic        rd    [2][2];
  logic [9:0]  maddr [2][2];
  logic [31:0] dout  [2][2];
  logic        rvld  [2][2];
  logic        rrdy  [2][2];
  logic [31:0] rdata [2][2];
  logic [3:0]  rtg   [2][2];

  logic [31:0] mem [1024];
  logic [9:0]  ach [2][2];

  typedef struct {
    logic [31:0] d;
    logic [3:0]  tag;
    int          t;
  } ent_t;

  ent_t sbq [4][$];
  int   LATv [2] = '{2, 0};
  int   DEPv [2] = '{4, 1};
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pops [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  mem_rdret_2ru #(.AW(10), .DW(32), .TW(4), .LATENCY(2), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .rreq_vld_0(vld[0][0]), .rreq_rdy_0(rdy[0][0]), .rreq_addr_0(raddr[0][0]), .rreq_tag_0(rtag[0][0]),
    .read_0(rd[0][0]), .addr_0(maddr[0][0]), .dout_0(dout[0][0]),
    .rsp_vld_0(rvld[0][0]), .rsp_rdy_0(rrdy[0][0]), .rsp_data_0(rdata[0][0]), .rsp_tag_0(rtg[0][0]),
    .rreq_vld_1(vld[0][1]), .rreq_rdy_1(rdy[0][1]), .rreq_addr_1(raddr[0][1]), .rreq_tag_1(rtag[0][1]),
    .read_1(rd[0][1]), .addr_1(maddr[0][1]), .dout_1(dout[0][1]),
    .rsp_vld_1(rvld[0][1]), .rsp_rdy_1(rrdy[0][1]), .rsp_data_1(rdata[0][1]), .rsp_tag_1(rtg[0][1])
  );

  mem_rdret_2ru #(.AW(10), .DW(32), .TW(4), .LATENCY(0), .FIFO_DEPTH(1)) u_dut_b (
    .clk(clk), .rst(rst),
    .rreq_vld_0(vld[1][0]), .rreq_rdy_0(rdy[1][0]), .rreq_addr_0(raddr[1][0]), .rreq_tag_0(rtag[1][0]),
    .read_0(rd[1][0]), .addr_0(maddr[1][0]), .dout_0(dout[1][0]),
    .rsp_vld_0(rvld[1][0]), .rsp_rdy_0(rrdy[1][0]), .rsp_data_0(rdata[1][0]), .rsp_tag_0(rtg[1][0]),
    .rreq_vld_1(vld[1][1]), .rreq_rdy_1(rdy[1][1]), .rreq_addr_1(raddr[1][1]), .rreq_tag_1(rtag[1][1]),
    .read_1(rd[1][1]), .addr_1(maddr[1][1]), .dout_1(dout[1][1]),
    .rsp_vld_1(rvld[1][1]), .rsp_rdy_1(rrdy[1][1]), .rsp_data_1(rdata[1][1]), .rsp_tag_1(rtg[1][1])
  );

  // Memory model: a 2-cycle address delay line for instance 0, a direct
  // lookup for the zero-latency instance 1.
  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      ach[p][0] <= maddr[0][p];
      ach[p][1] <= ach[p][0];
    end
  end
  assign dout[0][0] = mem[ach[0][1]];
  assign dout[0][1] = mem[ach[1][1]];
  assign dout[1][0] = mem[maddr[1][0]];
  assign dout[1][1] = mem[maddr[1][1]];

  task automatic chk(input string name, input int k, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s port=%0d cyc=%0d observed=%0h expected=%0h", name, k, cyc, obs, exp);
    end
  endtask

  task automatic eval_port(input int i, input int p);
    int   k;
    logic exp_rdy, acc, exp_vld;
    ent_t e;
    k       = i * 2 + p;
    exp_rdy = !rst && (sbq[k].size() < DEPv[i]);
    chk("rreq_rdy", k, rdy[i][p], exp_rdy);
    acc = vld[i][p] && exp_rdy;
    chk("read", k, rd[i][p], acc);
    if (acc) chk("addr", k, maddr[i][p], raddr[i][p]);
    exp_vld = !rst && (sbq[k].size() > 0) && (cyc >= sbq[k][0].t + LATv[i] + 1);
    chk("rsp_vld", k, rvld[i][p], exp_vld);
    if (exp_vld) begin
      chk("rsp_data", k, rdata[i][p], sbq[k][0].d);
      chk("rsp_tag", k, rtg[i][p], sbq[k][0].tag);
    end
    if (rst) begin
      sbq[k].delete();
    end else begin
      if (exp_vld && rrdy[i][p]) begin
        void'(sbq[k].pop_front());
        pops[k]++;
      end
      if (acc) begin
        e.d   = mem[raddr[i][p]];
        e.tag = rtag[i][p];
        e.t   = cyc;
        sbq[k].push_back(e);
      end
    end
  endtask

  // Check all ports mid-cycle, advance one clock, then return just after it.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) eval_port(i, p);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        vld[i][p]  = 1'b0;
        rrdy[i][p] = 1'b1;
        raddr[i][p] = 10'($urandom);
        rtag[i][p]  = 4'($urandom);
      end
  endtask

  task automatic req(input int i, input int p, input logic v, input logic [9:0] a, input logic [3:0] t);
    vld[i][p]   = v;
    raddr[i][p] = a;
    rtag[i][p]  = t;
  endtask

  initial begin
    int base;
    for (int a = 0; a < 1024; a++) mem[a] = $urandom;
    idle_all();
    rst = 1'b1;

    // Reset: requests offered during reset must be refused.
    req(0, 0, 1'b1, 10'h055, 4'd1);
    req(1, 1, 1'b1, 10'h066, 4'd2);
    repeat (3) step();
    idle_all();
    rst = 1'b0;
    step();

    // Single read, addr 0x10 tag 3, response after LATENCY+1 cycles.
    req(0, 0, 1'b1, 10'h010, 4'd3);
    step();
    req(0, 0, 1'b0, 10'h000, 4'd0);
    repeat (5) step();

    // Port 0 stalled until full while port 1 streams at full rate.
    rrdy[0][0] = 1'b0;
    repeat (2) step();
    base = pops[1];
    for (int n = 0; n < 20; n++) begin
      req(0, 0, 1'b1, 10'($urandom), 4'(n));
      req(0, 1, 1'b1, 10'($urandom), 4'(n + 5));
      step();
    end
    chk("p0_fill", 0, sbq[0].size(), 4);
    chk("p1_throughput", 1, pops[1] - base, 17);
    req(0, 1, 1'b0, 10'h000, 4'd0);
    rrdy[0][0] = 1'b1;
    step();
    rrdy[0][0] = 1'b0;
    repeat (3) step();
    idle_all();
    repeat (8) step();

    // Tags 0..3 back to back with random response stalls.
    for (int n = 0; n < 4; n++) begin
      req(0, 1, 1'b1, 10'($urandom), 4'(n));
      rrdy[0][1] = 1'($urandom_range(0, 1));
      step();
    end
    req(0, 1, 1'b0, 10'h000, 4'd0);
    for (int n = 0; n < 16; n++) begin
      rrdy[0][1] = 1'($urandom_range(0, 1));
      step();
    end
    idle_all();
    repeat (6) step();

    // Reset with two reads in flight: their data must never appear.
    req(0, 0, 1'b1, 10'h020, 4'd7);
    step();
    req(0, 0, 1'b1, 10'h021, 4'd8);
    step();
    req(0, 0, 1'b0, 10'h000, 4'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (6) step();

    // Zero-latency, single-entry instance: response next cycle, full until popped.
    rrdy[1][0] = 1'b0;
    req(1, 0, 1'b1, 10'h123, 4'd5);
    step();
    chk("b_full", 2, sbq[2].size(), 1);
    repeat (3) step();
    rrdy[1][0] = 1'b1;
    repeat (4) step();
    idle_all();
    step();

    // Randomized traffic on all four ports with occasional resets.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < 2; p++) begin
          req(i, p, 1'($urandom_range(0, 3) != 0), 10'($urandom), 4'($urandom));
          rrdy[i][p] = 1'($urandom_range(0, 2) != 0);
        end
      rst = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 1'b0;
    idle_all();
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
